// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calc_pkg;

  localparam int unsigned W         = 8;
  localparam int unsigned MA_BITS   = 4;
  localparam int unsigned MB_BITS   = 3;
  localparam int unsigned MUL_MAX_A = 15;
  localparam int unsigned MUL_MAX_B = 7;
  localparam int unsigned ACC_W     = MA_BITS + MB_BITS;
  localparam int unsigned STEP_W    = $clog2(MB_BITS + 1);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_MUL_STEP = 2'b01,
    S_DONE     = 2'b10
  } state_e;

  // Two's complement magnitude; -2**(W-1) maps to itself, which is out of any MUL range.
  function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
    return x[W-1] ? (W'(0) - x) : x;
  endfunction

endpackage

// File: rtl/calc_and_row.sv
// One partial-product row: a magnitude vector gated by a single multiplier bit.
module calc_and_row
  import calc_pkg::*;
(
  input  logic [MA_BITS-1:0] i_vec,
  input  logic               i_bit,
  output logic [MA_BITS-1:0] o_vec
);

  assign o_vec = i_vec & {MA_BITS{i_bit}};

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: single-step ADD/SUB, shift-and-add MUL,
// valid/ready handshakes on both request and result sides.
module calc_seq_ctrl
  import calc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         err,
  output logic         busy
);

  state_e             r_state;
  logic               r_in_ready;
  logic               r_res_valid;
  logic [W-1:0]       r_result;
  logic               r_ovf;
  logic               r_err;
  logic               r_busy;
  logic               r_sign;
  logic [MA_BITS-1:0] r_ma;
  logic [MB_BITS-1:0] r_mb;
  logic [ACC_W-1:0]   r_acc;
  logic [STEP_W-1:0]  r_step;

  op_e                w_op;
  logic [W-1:0]       w_sum;
  logic [W-1:0]       w_diff;
  logic [W-1:0]       w_neg_b;
  logic               w_ovf_add;
  logic               w_ovf_sub;
  logic [W-1:0]       w_abs_a;
  logic [W-1:0]       w_abs_b;
  logic               w_mul_ok;
  logic [MB_BITS:0]   w_mb_ext;
  logic [MA_BITS-1:0] w_row;
  logic [ACC_W-1:0]   w_pp;
  logic [ACC_W-1:0]   w_acc_next;
  logic [W-1:0]       w_prod;
  logic               w_last_step;

  // Single-step arithmetic and the MUL range check, evaluated on the live request.
  assign w_op      = op_e'(op);
  assign w_sum     = a + b;
  assign w_diff    = a - b;
  assign w_neg_b   = W'(0) - b;
  assign w_ovf_add = (a[W-1] == b[W-1])       && (w_sum[W-1]  != a[W-1]);
  assign w_ovf_sub = (a[W-1] == w_neg_b[W-1]) && (w_diff[W-1] != a[W-1]);
  assign w_abs_a   = abs_w(a);
  assign w_abs_b   = abs_w(b);
  assign w_mul_ok  = (w_abs_a <= W'(MUL_MAX_A)) && (w_abs_b <= W'(MUL_MAX_B));

  // Zero-extended so the step counter can index it over its full range.
  assign w_mb_ext = {1'b0, r_mb};

  calc_and_row u_and_row (
    .i_vec (r_ma),
    .i_bit (w_mb_ext[r_step]),
    .o_vec (w_row)
  );

  assign w_pp        = ACC_W'(w_row) << r_step;
  assign w_acc_next  = r_acc + w_pp;
  assign w_prod      = r_sign ? (W'(0) - W'(w_acc_next)) : W'(w_acc_next);
  assign w_last_step = (r_step == STEP_W'(MB_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_res_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_sign      <= 1'b0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_step      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            case (w_op)
              OP_ADD: begin
                r_result    <= w_sum;
                r_ovf       <= w_ovf_add;
                r_err       <= 1'b0;
                r_res_valid <= 1'b1;
                r_state     <= S_DONE;
              end
              OP_SUB: begin
                r_result    <= w_diff;
                r_ovf       <= w_ovf_sub;
                r_err       <= 1'b0;
                r_res_valid <= 1'b1;
                r_state     <= S_DONE;
              end
              OP_MUL: begin
                if (w_mul_ok) begin
                  r_sign  <= a[W-1] ^ b[W-1];
                  r_ma    <= w_abs_a[MA_BITS-1:0];
                  r_mb    <= w_abs_b[MB_BITS-1:0];
                  r_acc   <= '0;
                  r_step  <= '0;
                  r_state <= S_MUL_STEP;
                end else begin
                  r_result    <= '0;
                  r_ovf       <= 1'b0;
                  r_err       <= 1'b1;
                  r_res_valid <= 1'b1;
                  r_state     <= S_DONE;
                end
              end
              default: begin
                r_result    <= '0;
                r_ovf       <= 1'b0;
                r_err       <= 1'b1;
                r_res_valid <= 1'b1;
                r_state     <= S_DONE;
              end
            endcase
          end
        end

        // One partial-product row per cycle; the last row also loads the signed result.
        S_MUL_STEP: begin
          r_acc  <= w_acc_next;
          r_step <= r_step + STEP_W'(1);
          if (w_last_step) begin
            r_result    <= w_prod;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        // Result and flags stay put until consumed; the request side reopens a cycle later.
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign res_valid = r_res_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: vector table plus backpressure and mid-MUL reset sequences.
module tb_calc_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       ovf;
  logic       err;
  logic       busy;

  int n_checks;
  int n_errors;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ovf;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[15];

  calc_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .ovf       (ovf),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    wait_ready(v.name);
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, "_latency"}, lat, v.lat);
    chk({v.name, "_result"}, int'(result), int'(v.res));
    chk({v.name, "_ovf"}, int'(ovf), int'(v.ovf));
    chk({v.name, "_err"}, int'(err), int'(v.err));
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; op = 2'b00; a = '0; b = '0;

    //            name        op     a      b      res    ovf   err   lat
    vecs[0]  = '{"add_100_50",  2'b00, 8'd100, 8'd50,  8'h96, 1'b1, 1'b0, 1};
    vecs[1]  = '{"sub_3_10",    2'b01, 8'd3,   8'd10,  8'hF9, 1'b0, 1'b0, 1};
    vecs[2]  = '{"sub_80_1",    2'b01, 8'h80,  8'd1,   8'h7F, 1'b1, 1'b0, 1};
    vecs[3]  = '{"mul_15_7",    2'b10, 8'd15,  8'd7,   8'h69, 1'b0, 1'b0, 4};
    vecs[4]  = '{"mul_7_m5",    2'b10, 8'd7,   8'hFB,  8'hDD, 1'b0, 1'b0, 4};
    vecs[5]  = '{"mul_0_m1",    2'b10, 8'd0,   8'hFF,  8'h00, 1'b0, 1'b0, 4};
    vecs[6]  = '{"mul_m16_2",   2'b10, 8'hF0,  8'd2,   8'h00, 1'b0, 1'b1, 1};
    vecs[7]  = '{"rsvd",        2'b11, 8'd5,   8'd5,   8'h00, 1'b0, 1'b1, 1};
    vecs[8]  = '{"add_m1_m1",   2'b00, 8'hFF,  8'hFF,  8'hFE, 1'b0, 1'b0, 1};
    vecs[9]  = '{"add_127_1",   2'b00, 8'd127, 8'd1,   8'h80, 1'b1, 1'b0, 1};
    vecs[10] = '{"mul_m15_m7",  2'b10, 8'hF1,  8'hF9,  8'h69, 1'b0, 1'b0, 4};
    vecs[11] = '{"mul_m128_1",  2'b10, 8'h80,  8'd1,   8'h00, 1'b0, 1'b1, 1};
    vecs[12] = '{"mul_3_8",     2'b10, 8'd3,   8'd8,   8'h00, 1'b0, 1'b1, 1};
    vecs[13] = '{"add_80_80",   2'b00, 8'h80,  8'h80,  8'h00, 1'b1, 1'b0, 1};
    vecs[14] = '{"mul_5_m3",    2'b10, 8'd5,   8'hFD,  8'hF1, 1'b0, 1'b0, 4};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_result",    int'(result),    0);
    chk("rst_ovf",       int'(ovf),       0);
    chk("rst_err",       int'(err),       0);
    chk("rst_busy",      int'(busy),      0);

    // res_ready while no result is pending must not disturb anything
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    chk("idle_rr_res_valid", int'(res_valid), 0);
    chk("idle_rr_in_ready",  int'(in_ready),  1);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Backpressure on MUL 3*3 with a competing request held on the input
    wait_ready("bp");
    @(negedge clk); op = 2'b10; a = 8'd3; b = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 2'b00; a = 8'd2; b = 8'd3;
    for (int i = 0; i < 3; i++) begin
      chk("bp_step_busy", int'(busy), 1);
      chk("bp_step_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    chk("bp_res_valid", int'(res_valid), 1);
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold_result",    int'(result),    8'h09);
      chk("bp_hold_in_ready",  int'(in_ready),  0);
      chk("bp_hold_busy",      int'(busy),      1);
      chk("bp_hold_res_valid", int'(res_valid), 1);
      @(posedge clk); #1;
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    chk("bp_bubble_res_valid", int'(res_valid), 0);
    chk("bp_bubble_in_ready",  int'(in_ready),  1);
    chk("bp_bubble_busy",      int'(busy),      0);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("bp_next_res_valid", int'(res_valid), 1);
    chk("bp_next_result",    int'(result),    8'h05);
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;

    // Reset landing on the second MUL step discards the operation
    wait_ready("rst_mul");
    @(negedge clk); op = 2'b10; a = 8'd15; b = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("mrst_in_ready",  int'(in_ready),  1);
    chk("mrst_res_valid", int'(res_valid), 0);
    chk("mrst_result",    int'(result),    0);
    chk("mrst_ovf",       int'(ovf),       0);
    chk("mrst_err",       int'(err),       0);
    chk("mrst_busy",      int'(busy),      0);
    repeat (5) @(posedge clk);
    #1 chk("mrst_stays_idle", int'(res_valid), 0);
    run_vec('{"add_1_1", 2'b00, 8'd1, 8'd1, 8'h02, 1'b0, 1'b0, 1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Sequencing controller for the calculator datapath. Accepts one operation (ADD, SUB, MUL) per handshake on signed 8-bit operands and returns a signed 8-bit result with status flags.
- ADD/SUB complete in one step.
- MUL runs as a multi-cycle shift-and-add over a 4-bit x 3-bit magnitude multiplier. Each step's partial product comes from a per-bit AND row.
- Sits between the C++ operand-conversion front end and the result-conversion back end.

Parameters:
- W, 8, operand/result width (two's complement).
- MA_BITS, 4, multiplicand magnitude bits used by MUL (|a| <= 15).
- MB_BITS, 3, multiplier magnitude bits used by MUL (|b| <= 7); also the number of MUL step cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operation request valid.
- in_ready  out  1  controller can accept a request.
- op  in  2  00=ADD, 01=SUB, 10=MUL, 11=reserved.
- a  in  W  operand A, two's complement.
- b  in  W  operand B, two's complement.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- result  out  W  result, two's complement.
- ovf  out  1  ADD/SUB signed overflow.
- err  out  1  MUL magnitude out of range, or reserved op.
- busy  out  1  high in any state other than IDLE.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset values: state=IDLE, in_ready=1, res_valid=0, result=0, ovf=0, err=0, busy=0; accumulator and step counter = 0.
- States: IDLE, MUL_STEP, DONE.
- Request capture: accept when in_valid && in_ready, i.e. only in IDLE. op, a and b are registered at accept; later changes on the inputs are ignored.
- IDLE -> DONE (accept-to-res_valid = 1 cycle):
  - ADD: 9-bit sum registered; result = sum[W-1:0].
  - SUB: a - b registered; result = difference[W-1:0].
  - ovf = (sign a == sign of second operand) && (sign result != sign a), where the second operand is b for ADD and -b for SUB.
  - MUL with range violation: err=1, result=0.
  - op=11: err=1, result=0.
- IDLE -> MUL_STEP (MUL in range): latch sign = a[W-1]^b[W-1], ma = |a|[3:0], mb = |b|[2:0]; acc=0, step=0.
  - Range check: |a| <= 15 and |b| <= 7.
  - |-128| counts as out of range.
- MUL_STEP: each cycle, acc += (ma AND {MA_BITS{mb[step]}}) << step; step++.
  - After step MB_BITS-1 -> DONE.
  - result = sign ? -acc : acc, with acc max 105 (7 bits); ovf=0.
  - Accept-to-res_valid = MB_BITS+1 = 4 cycles.
- DONE: res_valid=1. result, ovf and err are held stable until res_ready=1, then -> IDLE.
  - Flags clear when the next result is loaded, not at handshake.
  - in_ready=0 in DONE; no accept in the same cycle as the result handshake (1 bubble cycle).
- Zero product with negative sign yields 0 (no -0).
- rst in any state, including mid-MUL_STEP: return to reset values next edge and discard the in-flight op.
- res_ready high while res_valid is low has no effect.

Decomposition:
- Package calc_pkg:
  - op_e enum (OP_ADD, OP_SUB, OP_MUL, OP_RSVD).
  - state_e enum.
  - W, MA_BITS, MB_BITS constants.
  - MUL_MAX_A=15, MUL_MAX_B=7.
- One sub-module calc_and_row: combinational MA_BITS-wide AND of a vector with a single bit. The MUL datapath instantiates it once per step, reusing the existing 1-bit AND cell.
- Everything else lives in calc_seq_ctrl.

Test Plan:
- ADD a=8'd100, b=8'd50 -> 1 cycle later res_valid=1, result=8'h96, ovf=1, err=0.
- SUB a=8'd3, b=8'd10 -> result=8'hF9 (-7), ovf=0; SUB a=8'h80, b=8'd1 -> result=8'h7F, ovf=1.
- MUL a=8'd15, b=8'd7 -> res_valid exactly 4 cycles after accept, result=8'h69 (105); MUL a=8'd7, b=8'hFB (-5) -> result=8'hDD (-35); MUL a=0, b=8'hFF -> result=8'h00.
- MUL a=8'hF0 (-16), b=8'd2 -> err=1, result=0 after 1 cycle; op=2'b11 -> err=1.
- Backpressure: MUL 3*3 with res_ready held low 6 cycles -> result=8'h09 stable, in_ready=0 and busy=1 throughout; new in_valid ignored until IDLE.
- Assert rst for one cycle during the 2nd MUL_STEP -> next cycle all outputs at reset values, in_ready=1; a following ADD 1+1 returns 8'h02.
